button_bank_debounce: RTL and testbench
=======================================

# button_bank_debounce

Parametrised multi-channel button front end: synchronises, debounces and edge-detects `NUM_BUTTONS` raw pushbutton inputs. Per channel it provides a clean level, single-cycle press and release pulses, a toggle-on-release state and optional hold-to-repeat pulses. It sits between board pins and the calculator/seven-segment control logic, replacing the per-button debounce, toggle and data-valid chain with one configurable block.

## Interface
- `NUM_BUTTONS`, 4, number of independent channels (1..16)
- `DEBOUNCE_CYCLES`, 250000, consecutive synchronised cycles a new level must hold before acceptance (≥2)
- `ACTIVE_LOW`, 0, 1 = raw pin reads 0 when pressed; inverted after synchronisation
- `REPEAT_DELAY`, 12500000, held cycles after press before the first repeat pulse (only with `AUTO_REPEAT_EN`)
- `REPEAT_PERIOD`, 2500000, cycles between subsequent repeat pulses (only with `AUTO_REPEAT_EN`)
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_buttons`  in  NUM_BUTTONS  raw, asynchronous pin levels
- `o_level`  out  NUM_BUTTONS  debounced level, 1 = pressed
- `o_press`  out  NUM_BUTTONS  1-cycle pulse on accepted press
- `o_release`  out  NUM_BUTTONS  1-cycle pulse on accepted release
- `o_toggle`  out  NUM_BUTTONS  flips on each accepted release
- `o_repeat`  out  NUM_BUTTONS  1-cycle auto-repeat pulse
- `o_dv`  out  1  high in any cycle where any `o_press` or `o_release` bit is high

## Operation
- Reset (async assert, sync release irrelevant): sync flops hold inactive level, counters 0, FSM IDLE, all outputs 0.
- Per channel: 2-flop synchroniser, then polarity correction (`ACTIVE_LOW`) gives `s`.
- Debounce: counter increments each cycle `s != o_level`; any cycle `s == o_level` clears it to 0. When counter == `DEBOUNCE_CYCLES-1` and `s` still differs, `o_level <= s` and counter clears. Glitches shorter than `DEBOUNCE_CYCLES` never propagate.
- Rising `o_level` → `o_press`=1 that cycle. Falling → `o_release`=1 and `o_toggle` inverts that cycle.
- Repeat FSM per channel: IDLE → HOLD on accepted press (repeat counter 0); HOLD → REPEAT when counter reaches `REPEAT_DELAY-1`, pulse `o_repeat`; REPEAT pulses `o_repeat` every `REPEAT_PERIOD` cycles; any state → IDLE on accepted release (no repeat pulse in the release cycle).
- Channels fully independent; simultaneous events on several channels all reported in the same cycle; `o_dv` is their OR.
- Reset mid-press: all state cleared; a still-held button is re-accepted as a fresh press `DEBOUNCE_CYCLES+2` cycles after reset deassertion.
- Counter width: `$clog2` of largest of the parameters used, +1; no overflow possible since counters clear at terminal count.

## Timing
- Latency: raw level change sampled at edge 0 → `o_level`/`o_press`/`o_release` change after edge `DEBOUNCE_CYCLES+1` (2 sync + debounce, registered).
- All outputs registered except `o_dv` (OR of registered pulses, same cycle).
- Pulses exactly one cycle wide; press and release of one channel never coincide.
- First `o_repeat` exactly `REPEAT_DELAY` cycles after `o_press`, then every `REPEAT_PERIOD`.

## Configuration
- `BUTTON_AUTO_REPEAT_EN` defined: repeat FSM and counter built as above.
- Undefined: FSM/counter not instantiated, `o_repeat` tied to 0, `REPEAT_*` ignored; all other behaviour identical.

## Structure
- Shared package `button_pkg`: repeat FSM state enum (IDLE, HOLD, REPEAT), `cnt_width` function, default timing constants for the 25 MHz board clock.
- Sub-module `button_channel`: one synchroniser + debounce + edge/toggle + repeat FSM; top generates `NUM_BUTTONS` instances and ORs `o_dv`.

## Test plan
(NUM_BUTTONS=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, macro defined)
- Clean press ch0 held 30 cycles → `o_press[0]` pulse 5 edges after sample, `o_level[0]`=1, `o_dv`=1 same cycle.
- Bounce ch0: 3-cycle high, 1 low, 3 high, then stable → no pulse until 4 consecutive stable cycles; exactly one `o_press`.
- Press then release ch1 → one `o_press`, one `o_release`, `o_toggle[1]` 0→1; repeat → 1→0.
- Hold ch0 50 cycles → `o_repeat[0]` at press+20, +28, +36, +44; none after release.
- Both channels pressed same cycle → `o_press`=2'b11 in one cycle, single `o_dv` cycle.
- Assert `rst` while ch0 held and toggle=1 → all outputs 0 immediately; after release of rst, `o_press[0]` 5 cycles later, `o_toggle` stays 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the button bank: repeat FSM states, counter sizing
// and default timing for the 25 MHz board clock.
// Optional feature macro used across the bank: BUTTON_AUTO_REPEAT_EN.
package button_pkg;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // 25 MHz board clock: 10 ms debounce, 500 ms first repeat, 100 ms repeat rate.
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_PERIOD   = 2500000;

  // Counter width able to hold max_count; one spare bit so the terminal
  // compare never sits on the top code.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/button_bank_debounce_if.sv
// Bus bundle between board pins and the button bank.
// Signalling: there is no back-pressure. o_press/o_release/o_repeat are
// single-cycle strobes, and o_dv is high exactly in the cycles where any
// press or release strobe is high; consumers must sample every cycle.
// o_rep_state exposes each channel's repeat FSM state (2 bits per channel).
interface button_bank_debounce_if #(
  parameter int NUM_BUTTONS = 4
);
  logic [NUM_BUTTONS-1:0]   i_buttons;
  logic [NUM_BUTTONS-1:0]   o_level;
  logic [NUM_BUTTONS-1:0]   o_press;
  logic [NUM_BUTTONS-1:0]   o_release;
  logic [NUM_BUTTONS-1:0]   o_toggle;
  logic [NUM_BUTTONS-1:0]   o_repeat;
  logic                     o_dv;
  logic [2*NUM_BUTTONS-1:0] o_rep_state;

  // Button bank side.
  modport slave (
    input  i_buttons,
    output o_level, o_press, o_release, o_toggle, o_repeat, o_dv, o_rep_state
  );

  // Pin / consumer side.
  modport master (
    output i_buttons,
    input  o_level, o_press, o_release, o_toggle, o_repeat, o_dv, o_rep_state
  );
endinterface

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, polarity fix, debounce counter,
// press/release/toggle generation and, with BUTTON_AUTO_REPEAT_EN defined,
// the hold-to-repeat FSM. Without the macro o_repeat is tied low.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_button,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_toggle,
  output logic       o_repeat,
  output rep_state_t o_rep_state
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_meta;
  logic            r_sync;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_s;
  logic            w_accept;
  logic            w_press_evt;
  logic            w_release_evt;

  // Synchroniser; resets to the pin's idle level so reset reads as released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= ACTIVE_LOW;
      r_sync <= ACTIVE_LOW;
    end else begin
      r_meta <= i_button;
      r_sync <= r_meta;
    end
  end

  assign w_s           = r_sync ^ ACTIVE_LOW;
  assign w_accept      = (w_s != o_level) && (r_db_cnt == DB_LAST);
  assign w_press_evt   = w_accept & w_s;
  assign w_release_evt = w_accept & ~w_s;

  // Debounce: a new level must persist DEBOUNCE_CYCLES cycles before it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt  <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_toggle  <= 1'b0;
    end else begin
      o_press   <= w_press_evt;
      o_release <= w_release_evt;
      if (w_s == o_level) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_db_cnt <= '0;
        o_level  <= w_s;
        if (w_release_evt) o_toggle <= ~o_toggle;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int              RP_W           = cnt_width(RP_MAX);
  localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  rep_state_t      r_state;
  logic [RP_W-1:0] r_rp_cnt;

  // Repeat FSM: wait REPEAT_DELAY after the press, then strobe every
  // REPEAT_PERIOD; an accepted release wins over any pending strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rp_cnt <= '0;
      o_repeat <= 1'b0;
    end else begin
      o_repeat <= 1'b0;
      if (w_release_evt) begin
        r_state  <= IDLE;
        r_rp_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_rp_cnt <= '0;
            if (w_press_evt) r_state <= HOLD;
          end
          HOLD: begin
            if (r_rp_cnt == RP_DELAY_LAST) begin
              r_state  <= REPEAT;
              r_rp_cnt <= '0;
              o_repeat <= 1'b1;
            end else begin
              r_rp_cnt <= r_rp_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (r_rp_cnt == RP_PERIOD_LAST) begin
              r_rp_cnt <= '0;
              o_repeat <= 1'b1;
            end else begin
              r_rp_cnt <= r_rp_cnt + 1'b1;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_rp_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign o_rep_state = r_state;
`else
  // Repeat timing has no effect without the repeat FSM; state stays IDLE.
  assign o_repeat    = 1'b0;
  assign o_rep_state = ((REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0)) ? IDLE : IDLE;
`endif

endmodule

// File: rtl/button_bank_debounce.sv
// Multi-channel button front end: NUM_BUTTONS independent debounce channels
// plus a shared data-valid strobe. Auto-repeat is built only when
// BUTTON_AUTO_REPEAT_EN is defined.
module button_bank_debounce
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic                   clk,
  input logic                   rst,
  button_bank_debounce_if.slave bus
);

  // One fully independent channel per button.
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_button   (bus.i_buttons[g]),
      .o_level    (bus.o_level[g]),
      .o_press    (bus.o_press[g]),
      .o_release  (bus.o_release[g]),
      .o_toggle   (bus.o_toggle[g]),
      .o_repeat   (bus.o_repeat[g]),
      .o_rep_state(bus.o_rep_state[2*g +: 2])
    );
  end

  // Data valid: any registered press or release strobe this cycle.
  assign bus.o_dv = |(bus.o_press | bus.o_release);

endmodule

// File: tb/tb_button_bank_debounce.sv
// Directed bench for button_bank_debounce: 2 channels, 4-cycle debounce,
// repeat delay 20 / period 8. Repeat expectations follow BUTTON_AUTO_REPEAT_EN.
module tb_button_bank_debounce;

  localparam int N  = 2;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  button_bank_debounce_if #(.NUM_BUTTONS(N)) bus ();

  button_bank_debounce #(
    .NUM_BUTTONS    (N),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW     (1'b0),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   32'(bus.o_level),   32'd0);
    chk({tag, "_press"},   32'(bus.o_press),   32'd0);
    chk({tag, "_release"}, 32'(bus.o_release), 32'd0);
    chk({tag, "_toggle"},  32'(bus.o_toggle),  32'd0);
    chk({tag, "_repeat"},  32'(bus.o_repeat),  32'd0);
    chk({tag, "_dv"},      32'(bus.o_dv),      32'd0);
  endtask

  initial begin
    int         cnt_a;
    int         cnt_b;
    int         at_j;
    logic [1:0] cap;
    logic [1:0] e_rep;

    // Reset state
    rst = 1'b1;
    bus.i_buttons = 2'b00;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (8) step();
    chk_all_zero("idle");

    // Clean press on ch0: visible after edge DB+1
    bus.i_buttons = 2'b01;
    repeat (5) step();
    chk("t1_pre_press", 32'(bus.o_press), 32'd0);
    chk("t1_pre_level", 32'(bus.o_level), 32'd0);
    step();
    chk("t1_press", 32'(bus.o_press), 32'd1);
    chk("t1_level", 32'(bus.o_level), 32'd1);
    chk("t1_dv",    32'(bus.o_dv),    32'd1);

    // Hold ch0: repeats at press+20, +28, +36, +44
    for (int k = 1; k <= 45; k++) begin
      step();
      e_rep = (REP_ON && (k == 20 || k == 28 || k == 36 || k == 44)) ? 2'b01 : 2'b00;
      chk("hold_repeat", 32'(bus.o_repeat), 32'(e_rep));
      if (k == 1) chk("hold_press_width", 32'(bus.o_press), 32'd0);
    end

    // Release ch0: one release, toggle 0->1, no repeat afterwards
    bus.i_buttons = 2'b00;
    repeat (5) step();
    chk("t1_pre_release", 32'(bus.o_release), 32'd0);
    step();
    chk("t1_release",    32'(bus.o_release), 32'd1);
    chk("t1_rel_level",  32'(bus.o_level),   32'd0);
    chk("t1_rel_toggle", 32'(bus.o_toggle),  32'd1);
    chk("t1_rel_dv",     32'(bus.o_dv),      32'd1);
    cnt_a = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.o_repeat != 2'b00) cnt_a++;
    end
    chk("post_release_repeats", 32'(cnt_a), 32'd0);

    // Bounce on ch0: 3 high, 1 low, then high; accepted after 4 stable cycles
    bus.i_buttons = 2'b01;
    cnt_a = 0;
    at_j  = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (bus.o_press[0]) begin
        cnt_a++;
        at_j = j;
      end
      bus.i_buttons = (j == 3) ? 2'b00 : 2'b01;
    end
    chk("bounce_press_count", 32'(cnt_a), 32'd1);
    chk("bounce_press_step",  32'(at_j),  32'd10);
    chk("bounce_level",       32'(bus.o_level), 32'd1);

    // Release ch0 after bounce: toggle 1->0, no repeat in the window
    bus.i_buttons = 2'b00;
    cnt_a = 0;
    cnt_b = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (bus.o_release[0]) cnt_a++;
      if (bus.o_repeat[0]) cnt_b++;
    end
    chk("bounce_release_count", 32'(cnt_a), 32'd1);
    chk("bounce_repeat_count",  32'(cnt_b), 32'd0);
    chk("bounce_toggle",        32'(bus.o_toggle), 32'd0);

    // ch1 press/release twice: toggle[1] 0->1->0
    for (int r = 0; r < 2; r++) begin
      bus.i_buttons = 2'b10;
      cnt_a = 0;
      cnt_b = 0;
      for (int j = 0; j < 12; j++) begin
        step();
        if (bus.o_press[1]) cnt_a++;
        if ((bus.o_press & bus.o_release) != 2'b00) cnt_b++;
      end
      chk("ch1_press_count", 32'(cnt_a), 32'd1);
      chk("ch1_toggle_held", 32'(bus.o_toggle[1]), 32'(r));
      bus.i_buttons = 2'b00;
      cnt_a = 0;
      for (int j = 0; j < 12; j++) begin
        step();
        if (bus.o_release[1]) cnt_a++;
        if ((bus.o_press & bus.o_release) != 2'b00) cnt_b++;
      end
      chk("ch1_release_count", 32'(cnt_a), 32'd1);
      chk("ch1_coincide",      32'(cnt_b), 32'd0);
      chk("ch1_toggle_after",  32'(bus.o_toggle[1]), (r == 0) ? 32'd1 : 32'd0);
    end

    // Both channels in the same cycle: one dv cycle carrying 2'b11
    bus.i_buttons = 2'b11;
    cnt_a = 0;
    cap   = 2'b00;
    for (int j = 0; j < 12; j++) begin
      step();
      if (bus.o_dv) begin
        cnt_a++;
        cap = bus.o_press;
      end
    end
    chk("both_press_dv_count", 32'(cnt_a), 32'd1);
    chk("both_press_value",    32'(cap),   32'd3);
    bus.i_buttons = 2'b00;
    cnt_a = 0;
    cap   = 2'b00;
    for (int j = 0; j < 12; j++) begin
      step();
      if (bus.o_dv) begin
        cnt_a++;
        cap = bus.o_release;
      end
    end
    chk("both_release_dv_count", 32'(cnt_a), 32'd1);
    chk("both_release_value",    32'(cap),   32'd3);
    chk("both_toggle",           32'(bus.o_toggle), 32'd3);

    // Reset while ch0 held with toggles set
    bus.i_buttons = 2'b01;
    repeat (12) step();
    chk("pre_rst_level",  32'(bus.o_level),  32'd1);
    chk("pre_rst_toggle", 32'(bus.o_toggle), 32'd3);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step(); step();
    chk_all_zero("rst_held");
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("rst_repress", 32'(bus.o_press), (j == 6) ? 32'd1 : 32'd0);
      chk("rst_toggle",  32'(bus.o_toggle), 32'd0);
    end
    chk("rst_relevel", 32'(bus.o_level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
